// File: rtl/core_mem_arbiter_if.sv
// Core-array <-> DRAM front-end bundle: core request lanes, DRAM port and run status.
interface core_mem_arbiter_if #(
  parameter int N_CORES = 4,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16
);
  logic                         start;
  logic [N_CORES-1:0]           core_req;
  logic [N_CORES-1:0]           core_we;
  logic [N_CORES*ADDR_W-1:0]    core_addr;
  logic [N_CORES*DATA_W-1:0]    core_wdata;
  logic [N_CORES-1:0]           core_end;
  logic [N_CORES-1:0]           core_gnt;
  logic [N_CORES-1:0]           core_rvalid;
  logic [DATA_W-1:0]            core_rdata;
  logic [ADDR_W-1:0]            dram_addr;
  logic [DATA_W-1:0]            dram_wdata;
  logic                         dram_wren;
  logic [DATA_W-1:0]            dram_rdata;
  logic [1:0]                   status;
  logic                         all_done;
  logic [31:0]                  run_cycles;

  // Arbiter side
  modport slave (
    input  start, core_req, core_we, core_addr, core_wdata, core_end, dram_rdata,
    output core_gnt, core_rvalid, core_rdata, dram_addr, dram_wdata, dram_wren,
           status, all_done, run_cycles
  );

  // Core array / DRAM side
  modport master (
    output start, core_req, core_we, core_addr, core_wdata, core_end, dram_rdata,
    input  core_gnt, core_rvalid, core_rdata, dram_addr, dram_wdata, dram_wren,
           status, all_done, run_cycles
  );
endinterface

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: round-robin shared-DRAM front end for N cores, with a
// run FSM (IDLE/RUN/DONE) fed by the per-core end_process levels.
module core_mem_arbiter #(
  parameter int N_CORES = 4,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int RD_LAT  = 2
) (
  input logic               clock,
  input logic               rst_n,
  core_mem_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  localparam int PTR_W = $clog2(N_CORES);
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);
  localparam logic [PTR_W:0]   N_EXT    = (PTR_W+1)'(N_CORES);
  localparam logic [PTR_W-1:0] LAST     = PTR_W'(N_CORES - 1);

  logic [1:0]          st_q, st_d;
  logic [31:0]         run_cycles_q, run_cycles_d;
  logic [PTR_W-1:0]    rr_q, rr_d;
  logic [N_CORES-1:0]  gnt_q, gnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wren_q, wren_d;
  logic                rd_pend_q, rd_pend_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [N_CORES-1:0]  rd_core_q, rd_core_d;
  logic [N_CORES-1:0]  rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                rd_done, go_done, arb_en, found, grant, rd_issue;
  logic [N_CORES-1:0]  req_m, sel_oh;
  logic [PTR_W-1:0]    sel;
  logic [PTR_W:0]      idx;

  // rd_done: the outstanding read's data is on dram_rdata this cycle.
  // The grant slot opens on that same edge, so the next grant lands in G+RD_LAT.
  assign rd_done = rd_pend_q && (rd_cnt_q == '0);
  assign go_done = (st_q == S_RUN) && (&bus.core_end) && !rd_pend_q;
  // No new grant on the edge that leaves RUN, so DONE never sees a DRAM access.
  assign arb_en  = (st_q == S_RUN) && !go_done && (!rd_pend_q || rd_done);
  // The core granted this cycle still shows its old request; keep it out.
  assign req_m   = bus.core_req & ~gnt_q;
  assign grant   = arb_en && found;
  assign sel_oh  = N_CORES'(1) << sel;
  assign rd_issue = grant && !bus.core_we[sel];

  // Round-robin search: first masked request at or after the pointer.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 0; k < N_CORES; k++) begin
      idx = {1'b0, rr_q} + (PTR_W+1)'(k);
      if (idx >= N_EXT) idx = idx - N_EXT;
      if (!found && req_m[idx[PTR_W-1:0]]) begin
        found = 1'b1;
        sel   = idx[PTR_W-1:0];
      end
    end
  end

  // Next-state for run FSM, grant/DRAM registers and read-return tracking.
  always_comb begin
    st_d = st_q;
    case (st_q)
      S_IDLE:  if (bus.start) st_d = S_RUN;
      S_RUN:   if (go_done)   st_d = S_DONE;
      S_DONE:  if (bus.start) st_d = S_RUN;
      default: st_d = S_IDLE;
    endcase

    run_cycles_d = run_cycles_q;
    if (st_q == S_DONE && bus.start)               run_cycles_d = '0;
    else if (st_q == S_RUN && run_cycles_q != '1)  run_cycles_d = run_cycles_q + 32'd1;

    gnt_d   = grant ? sel_oh : '0;
    wren_d  = grant && bus.core_we[sel];
    addr_d  = grant ? bus.core_addr[sel*ADDR_W +: ADDR_W]  : addr_q;
    wdata_d = grant ? bus.core_wdata[sel*DATA_W +: DATA_W] : wdata_q;
    rr_d    = grant ? ((sel == LAST) ? '0 : sel + 1'b1) : rr_q;

    rvalid_d = rd_done ? rd_core_q : '0;
    rdata_d  = rd_done ? bus.dram_rdata : rdata_q;

    rd_pend_d = rd_pend_q;
    rd_cnt_d  = rd_cnt_q;
    rd_core_d = rd_core_q;
    if (rd_issue) begin
      rd_pend_d = 1'b1;
      rd_cnt_d  = CNT_INIT;
      rd_core_d = sel_oh;
    end else if (rd_done) begin
      rd_pend_d = 1'b0;
    end else if (rd_pend_q) begin
      rd_cnt_d  = rd_cnt_q - 1'b1;
    end
  end

  // State registers; reset drops any read in flight.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      st_q         <= S_IDLE;
      run_cycles_q <= '0;
      rr_q         <= '0;
      gnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wren_q       <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_cnt_q     <= '0;
      rd_core_q    <= '0;
      rvalid_q     <= '0;
      rdata_q      <= '0;
    end else begin
      st_q         <= st_d;
      run_cycles_q <= run_cycles_d;
      rr_q         <= rr_d;
      gnt_q        <= gnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wren_q       <= wren_d;
      rd_pend_q    <= rd_pend_d;
      rd_cnt_q     <= rd_cnt_d;
      rd_core_q    <= rd_core_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
    end
  end

  assign bus.core_gnt    = gnt_q;
  assign bus.core_rvalid = rvalid_q;
  assign bus.core_rdata  = rdata_q;
  assign bus.dram_addr   = addr_q;
  assign bus.dram_wdata  = wdata_q;
  assign bus.dram_wren   = wren_q;
  assign bus.status      = st_q;
  assign bus.all_done    = (st_q == S_DONE);
  assign bus.run_cycles  = run_cycles_q;
endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level round-robin model.
module tb_core_mem_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int RL = 2;
  localparam int OW = 2 + 1 + N + N + DW + AW + DW + 1 + 32;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_tot  = 0;

  always #5 clock = ~clock;

  core_mem_arbiter_if #(.N_CORES(N), .DATA_W(DW), .ADDR_W(AW)) bus ();

  core_mem_arbiter #(.N_CORES(N), .DATA_W(DW), .ADDR_W(AW), .RD_LAT(RL)) dut (
    .clock(clock),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // DRAM stand-in: returns a fixed function of the address seen one cycle earlier
  logic [AW-1:0] a_d;
  logic          force_en  = 1'b0;
  logic [DW-1:0] force_val = '0;

  function automatic logic [DW-1:0] dram_f(input logic [AW-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  always @(posedge clock) a_d <= bus.dram_addr;
  assign bus.dram_rdata = force_en ? force_val : dram_f(a_d);

  function automatic logic [OW-1:0] all_outs();
    return {bus.status, bus.all_done, bus.core_gnt, bus.core_rvalid, bus.core_rdata,
            bus.dram_addr, bus.dram_wdata, bus.dram_wren, bus.run_cycles};
  endfunction

  task automatic clr_inputs();
    bus.start = 1'b0; bus.core_req = '0; bus.core_we = '0;
    bus.core_addr = '0; bus.core_wdata = '0; bus.core_end = '0;
  endtask

  task automatic set_core(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.core_req[i] = 1'b1;
    bus.core_we[i]  = we;
    bus.core_addr[i*AW +: AW]  = a;
    bus.core_wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst_n = 1'b0;
    clr_inputs();
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
  endtask

  // Called at a negedge; returns at the negedge of the first RUN cycle.
  task automatic start_run();
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    clr_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clock);
    n_tot++; if (all_outs() !== '0) $display("FAIL reset_outputs: got %h want 0", all_outs()); else n_pass++;
    rst_n = 1'b1;
    @(negedge clock);
    start_run();
    set_core(0, 1'b0, 16'h0010, 16'h0000);
    @(negedge clock);
    n_tot++; if (bus.core_gnt !== 4'b0001) $display("FAIL reset_rd_gnt: got %b want 0001", bus.core_gnt); else n_pass++;
    clr_inputs();
    rst_n = 1'b0;
    #1;
    n_tot++; if (all_outs() !== '0) $display("FAIL reset_async: got %h want 0", all_outs()); else n_pass++;
    @(negedge clock);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      n_tot++;
      if (bus.core_rvalid !== '0 || bus.status !== 2'b00)
        $display("FAIL reset_no_rvalid: cyc %0d rvalid %b status %b want 0000/00", k, bus.core_rvalid, bus.status);
      else n_pass++;
    end
  endtask

  task automatic test_single_write();
    start_run();
    set_core(1, 1'b1, 16'h0040, 16'h1234);
    @(negedge clock);
    n_tot++; if (bus.core_gnt !== 4'b0010) $display("FAIL wr_gnt: got %b want 0010", bus.core_gnt); else n_pass++;
    n_tot++; if (bus.dram_wren !== 1'b1) $display("FAIL wr_wren: got %b want 1", bus.dram_wren); else n_pass++;
    n_tot++; if (bus.dram_addr !== 16'h0040) $display("FAIL wr_addr: got %h want 0040", bus.dram_addr); else n_pass++;
    n_tot++; if (bus.dram_wdata !== 16'h1234) $display("FAIL wr_wdata: got %h want 1234", bus.dram_wdata); else n_pass++;
    clr_inputs();
    @(negedge clock);
    n_tot++;
    if (bus.core_gnt !== '0 || bus.dram_wren !== 1'b0 || bus.dram_addr !== 16'h0040)
      $display("FAIL wr_idle: gnt %b wren %b addr %h want 0000/0/0040", bus.core_gnt, bus.dram_wren, bus.dram_addr);
    else n_pass++;
  endtask

  task automatic test_read_latency();
    bit ok;
    force_en = 1'b1; force_val = 16'hBEEF;
    set_core(0, 1'b0, 16'h0010, 16'h0000);
    @(negedge clock);
    n_tot++;
    if (bus.core_gnt !== 4'b0001 || bus.dram_wren !== 1'b0 || bus.dram_addr !== 16'h0010)
      $display("FAIL rd_gnt: gnt %b wren %b addr %h want 0001/0/0010", bus.core_gnt, bus.dram_wren, bus.dram_addr);
    else n_pass++;
    clr_inputs();
    set_core(2, 1'b1, 16'h0200, 16'h2222);
    @(negedge clock);
    n_tot++;
    if (bus.core_gnt !== '0 || bus.core_rvalid !== '0)
      $display("FAIL rd_gap: gnt %b rvalid %b want 0000/0000", bus.core_gnt, bus.core_rvalid);
    else n_pass++;
    @(negedge clock);
    n_tot++; if (bus.core_rvalid !== 4'b0001) $display("FAIL rd_rvalid: got %b want 0001", bus.core_rvalid); else n_pass++;
    n_tot++; if (bus.core_rdata !== 16'hBEEF) $display("FAIL rd_rdata: got %h want beef", bus.core_rdata); else n_pass++;
    ok = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (bus.core_gnt === 4'b0100) begin ok = 1'b1; break; end
      @(negedge clock);
    end
    n_tot++; if (!ok) $display("FAIL rd_next_gnt: got %b want 0100 within 4 cycles", bus.core_gnt); else n_pass++;
    clr_inputs();
    force_en = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_fairness();
    int s[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0]  eg;
    logic [AW-1:0] ea;
    do_reset();
    start_run();
    for (int i = 0; i < N; i++) set_core(i, 1'b1, 16'h1000 + 16'(i), 16'hA000 + 16'(i));
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      eg = 4'b0001 << s[k];
      ea = 16'h1000 + 16'(s[k]);
      n_tot++;
      if (bus.core_gnt !== eg || bus.dram_addr !== ea)
        $display("FAIL rr_order: step %0d gnt %b addr %h want %b/%h", k, bus.core_gnt, bus.dram_addr, eg, ea);
      else n_pass++;
    end
    clr_inputs();
    @(negedge clock);
  endtask

  task automatic test_done();
    do_reset();
    start_run();
    n_tot++;
    if (bus.status !== 2'b01 || bus.run_cycles !== 32'd0)
      $display("FAIL done_run0: status %b cycles %0d want 01/0", bus.status, bus.run_cycles);
    else n_pass++;
    set_core(1, 1'b0, 16'h0123, 16'h0000);
    @(negedge clock);
    n_tot++; if (bus.core_gnt !== 4'b0010) $display("FAIL done_gnt: got %b want 0010", bus.core_gnt); else n_pass++;
    clr_inputs();
    bus.core_end = '1;
    @(negedge clock);
    n_tot++; if (bus.status !== 2'b01) $display("FAIL done_hold: status %b want 01", bus.status); else n_pass++;
    @(negedge clock);
    n_tot++;
    if (bus.core_rvalid !== 4'b0010 || bus.core_rdata !== dram_f(16'h0123) || bus.status !== 2'b01 || bus.run_cycles !== 32'd3)
      $display("FAIL done_rvalid: rvalid %b rdata %h status %b cycles %0d want 0010/%h/01/3",
               bus.core_rvalid, bus.core_rdata, bus.status, bus.run_cycles, dram_f(16'h0123));
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      n_tot++;
      if (bus.status !== 2'b10 || bus.all_done !== 1'b1 || bus.run_cycles !== 32'd4)
        $display("FAIL done_state: cyc %0d status %b all_done %b cycles %0d want 10/1/4",
                 k, bus.status, bus.all_done, bus.run_cycles);
      else n_pass++;
    end
    bus.core_end = '0;
    start_run();
    n_tot++;
    if (bus.status !== 2'b01 || bus.all_done !== 1'b0 || bus.run_cycles !== 32'd0)
      $display("FAIL done_restart: status %b all_done %b cycles %0d want 01/0/0", bus.status, bus.all_done, bus.run_cycles);
    else n_pass++;
  endtask

  task automatic test_guard();
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    n_tot++;
    if (bus.status !== 2'b01 || bus.run_cycles !== 32'd1)
      $display("FAIL guard_start_run: status %b cycles %0d want 01/1", bus.status, bus.run_cycles);
    else n_pass++;
    bus.core_end = '1;
    @(negedge clock);
    n_tot++; if (bus.status !== 2'b10) $display("FAIL guard_to_done: status %b want 10", bus.status); else n_pass++;
    for (int i = 0; i < N; i++) set_core(i, 1'b1, 16'h3000 + 16'(i), 16'h0000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      n_tot++; if (bus.core_gnt !== '0) $display("FAIL guard_done_gnt: cyc %0d got %b want 0000", k, bus.core_gnt); else n_pass++;
    end
    rst_n = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      n_tot++;
      if (bus.core_gnt !== '0 || bus.status !== 2'b00)
        $display("FAIL guard_idle_gnt: cyc %0d gnt %b status %b want 0000/00", k, bus.core_gnt, bus.status);
      else n_pass++;
    end
    clr_inputs();
  endtask

  // Model: each core holds one pending access until granted; the grant for a
  // cycle goes to the first pending core at or after the pointer, excluding the
  // core granted in the previous cycle, and never inside a read's latency window.
  task automatic test_random();
    bit            pend[N];
    logic          pwe[N];
    logic [AW-1:0] pa[N];
    logic [DW-1:0] pd[N];
    int            ptr, busy, exp_g, mask, idx;
    int            rv_cyc[$];
    int            rv_core[$];
    logic [DW-1:0] rv_dat[$];
    logic [N-1:0]  eg, erv;
    do_reset();
    start_run();
    ptr = 0; busy = 0; exp_g = -1;
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; pwe[i] = 1'b0; pa[i] = '0; pd[i] = '0; end
    for (int c = 0; c < 400; c++) begin
      eg = (exp_g >= 0) ? (4'b0001 << exp_g) : '0;
      n_tot++; if (bus.core_gnt !== eg) $display("FAIL rnd_gnt: cyc %0d got %b want %b", c, bus.core_gnt, eg); else n_pass++;
      n_tot++;
      if (exp_g >= 0) begin
        if (bus.dram_wren !== pwe[exp_g] || bus.dram_addr !== pa[exp_g] || (pwe[exp_g] && bus.dram_wdata !== pd[exp_g]))
          $display("FAIL rnd_access: cyc %0d wren %b addr %h wdata %h want %b/%h/%h",
                   c, bus.dram_wren, bus.dram_addr, bus.dram_wdata, pwe[exp_g], pa[exp_g], pd[exp_g]);
        else n_pass++;
      end else begin
        if (bus.dram_wren !== 1'b0) $display("FAIL rnd_wren_idle: cyc %0d got %b want 0", c, bus.dram_wren);
        else n_pass++;
      end
      erv = '0;
      if (rv_cyc.size() > 0 && rv_cyc[0] == c) erv = 4'b0001 << rv_core[0];
      n_tot++; if (bus.core_rvalid !== erv) $display("FAIL rnd_rvalid: cyc %0d got %b want %b", c, bus.core_rvalid, erv); else n_pass++;
      if (erv != '0) begin
        n_tot++; if (bus.core_rdata !== rv_dat[0]) $display("FAIL rnd_rdata: cyc %0d got %h want %h", c, bus.core_rdata, rv_dat[0]); else n_pass++;
        void'(rv_cyc.pop_front()); void'(rv_core.pop_front()); void'(rv_dat.pop_front());
      end
      mask = -1;
      if (exp_g >= 0) begin
        if (!pwe[exp_g]) begin
          rv_cyc.push_back(c + RL); rv_core.push_back(exp_g); rv_dat.push_back(dram_f(pa[exp_g]));
          busy = c + RL;
        end
        ptr = (exp_g + 1) % N;
        pend[exp_g] = 1'b0;
        mask = exp_g;
      end
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && c < 360 && $urandom_range(2) == 0) begin
          pend[i] = 1'b1;
          pwe[i]  = 1'($urandom_range(1));
          pa[i]   = 16'($urandom);
          pd[i]   = 16'($urandom);
        end
        bus.core_req[i] = pend[i];
        bus.core_we[i]  = pwe[i];
        bus.core_addr[i*AW +: AW]  = pa[i];
        bus.core_wdata[i*DW +: DW] = pd[i];
      end
      exp_g = -1;
      if (c + 1 >= busy) begin
        for (int k = 0; k < N; k++) begin
          idx = (ptr + k) % N;
          if (exp_g < 0 && pend[idx] && idx != mask) exp_g = idx;
        end
      end
      @(negedge clock);
    end
    clr_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    clr_inputs();
    test_reset();
    test_single_write();
    test_read_latency();
    test_fairness();
    test_done();
    test_guard();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
